// File: rtl/qpp_deinterleaver.sv
// qpp_deinterleaver
//   Block-level QPP turbo deinterleaver. K soft samples arrive in interleaved
//   order; sample i is written to buffer address pi(i) = (f1*i + f2*i^2) mod K
//   and the buffer is then read out in natural order.
//   pi(i) is generated without multipliers by the second-order recurrence
//     pi <- (pi + g) mod K,  g <- (g + d) mod K,
//   starting from pi = 0, g = (f1+f2) mod K, d = (2*f2) mod K.
//
//   Optional feature: define QPP_INTERLEAVE_MODE_EN to add input `mode`.
//   With mode=1 the block interleaves instead: it writes sequentially and reads
//   mem[pi], restarting the recurrence when READ begins.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   start             one-cycle pulse latching k_len/f1/f2 (IDLE only)
//   k_len, f1, f2     block length and QPP coefficients (f1, f2 < K)
//   mode              (QPP_INTERLEAVE_MODE_EN only) 1 = interleave direction
//   din, din_valid    input samples, accepted while din_ready is high
//   din_ready         high in WRITE only
//   dout, dout_valid  deinterleaved samples, held while dout_ready is low
//   dout_ready        downstream ready
//   dout_last         marks the final sample of the block
//   busy              high whenever the block is not IDLE
//   err               one-cycle pulse for a start with k_len=0 or k_len>MAX_K
module qpp_deinterleaver #(
  parameter int DW    = 8,
  parameter int KW    = 13,
  parameter int MAX_K = 6144
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [KW-1:0] k_len,
  input  logic [8:0]    f1,
  input  logic [9:0]    f2,
`ifdef QPP_INTERLEAVE_MODE_EN
  input  logic          mode,
`endif
  input  logic [DW-1:0] din,
  input  logic          din_valid,
  output logic          din_ready,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic          dout_last,
  output logic          busy,
  output logic          err
);

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

  // Modular add for operands already below k: one compare-subtract.
  function automatic logic [KW-1:0] mod_add(input logic [KW-1:0] a,
                                            input logic [KW-1:0] b,
                                            input logic [KW-1:0] k);
    logic [KW:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, k}) s = s - {1'b0, k};
    return s[KW-1:0];
  endfunction

  state_t        state;
  logic [KW-1:0] k_reg;
  logic [KW-1:0] pi;
  logic [KW-1:0] g;
  logic [KW-1:0] d;
  logic [KW-1:0] wr_cnt;
  logic [KW-1:0] rd_addr;
  logic          rd_done;
  logic          vld_p1;
  logic          last_p1;
  logic [DW-1:0] rd_data_p1;

  logic [DW-1:0] mem [MAX_K];

  logic [KW-1:0] f1_ext;
  logic [KW-1:0] f2_ext;
  logic [KW-1:0] k_m1;
  logic          k_ok;
  logic          wr_fire;
  logic          advance;
  logic          rd_en;
  logic          out_done;
  logic [KW-1:0] wr_addr;
  logic [KW-1:0] rd_addr_mux;

`ifdef QPP_INTERLEAVE_MODE_EN
  logic          mode_reg;
  logic [KW-1:0] g0;
`endif

  assign f1_ext   = {{(KW-9){1'b0}}, f1};
  assign f2_ext   = {{(KW-10){1'b0}}, f2};
  assign k_m1     = k_reg - 1'b1;
  assign k_ok     = (k_len != '0) && (k_len <= KW'(MAX_K));
  assign wr_fire  = (state == WRITE) && din_valid && din_ready;
  // The output register can take a new word when empty or being drained.
  assign advance  = !dout_valid || dout_ready;
  // Only fetch when the RAM output stage is free or moving on, so a stalled
  // word in rd_data_p1 is never overwritten.
  assign rd_en    = (state == READ) && !rd_done && (!vld_p1 || advance);
  assign out_done = dout_valid && dout_ready && dout_last;

`ifdef QPP_INTERLEAVE_MODE_EN
  assign wr_addr     = mode_reg ? wr_cnt : pi;
  assign rd_addr_mux = mode_reg ? pi : rd_addr;
`else
  assign wr_addr     = pi;
  assign rd_addr_mux = rd_addr;
`endif

  // Block buffer: synchronous write, registered read (stage p0 -> p1)
  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_addr] <= din;
    if (rd_en)   rd_data_p1   <= mem[rd_addr_mux];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      din_ready  <= 1'b0;
      err        <= 1'b0;
      k_reg      <= '0;
      pi         <= '0;
      g          <= '0;
      d          <= '0;
      wr_cnt     <= '0;
      rd_addr    <= '0;
      rd_done    <= 1'b0;
      vld_p1     <= 1'b0;
      last_p1    <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
      dout_last  <= 1'b0;
`ifdef QPP_INTERLEAVE_MODE_EN
      mode_reg   <= 1'b0;
      g0         <= '0;
`endif
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (k_ok) begin
              k_reg     <= k_len;
              pi        <= '0;
              g         <= mod_add(f1_ext, f2_ext, k_len);
              d         <= mod_add(f2_ext, f2_ext, k_len);
              wr_cnt    <= '0;
              rd_addr   <= '0;
              rd_done   <= 1'b0;
              state     <= WRITE;
              busy      <= 1'b1;
              din_ready <= 1'b1;
`ifdef QPP_INTERLEAVE_MODE_EN
              g0        <= mod_add(f1_ext, f2_ext, k_len);
              mode_reg  <= mode;
`endif
            end else begin
              err <= 1'b1;
            end
          end
        end
        WRITE: begin
          if (wr_fire) begin
            pi     <= mod_add(pi, g, k_reg);
            g      <= mod_add(g, d, k_reg);
            wr_cnt <= wr_cnt + 1'b1;
            if (wr_cnt == k_m1) begin
              state     <= READ;
              din_ready <= 1'b0;
`ifdef QPP_INTERLEAVE_MODE_EN
              // Interleave reads walk the same recurrence from its start.
              pi        <= '0;
              g         <= g0;
`endif
            end
          end
        end
        READ: begin
          if (rd_en) begin
            rd_addr <= rd_addr + 1'b1;
            if (rd_addr == k_m1) rd_done <= 1'b1;
`ifdef QPP_INTERLEAVE_MODE_EN
            pi      <= mod_add(pi, g, k_reg);
            g       <= mod_add(g, d, k_reg);
`endif
          end
          if (out_done) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          din_ready <= 1'b0;
        end
      endcase

      // Stage p1: RAM output valid tracking
      if (rd_en) begin
        vld_p1  <= 1'b1;
        last_p1 <= (rd_addr == k_m1);
      end else if (advance) begin
        vld_p1  <= 1'b0;
      end

      // Stage p2: registered output word
      if (advance) begin
        dout_valid <= vld_p1;
        dout_last  <= vld_p1 && last_p1;
        if (vld_p1) dout <= rd_data_p1;
      end
    end
  end

endmodule

// File: tb/tb_qpp_deinterleaver.sv
module tb_qpp_deinterleaver;

  localparam int DW = 8;
  localparam int KW = 13;
  localparam int MAX_K = 6144;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [KW-1:0] k_len;
  logic [8:0]    f1;
  logic [9:0]    f2;
`ifdef QPP_INTERLEAVE_MODE_EN
  logic          mode;
`endif
  logic [DW-1:0] din;
  logic          din_valid;
  logic          din_ready;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready;
  logic          dout_last;
  logic          busy;
  logic          err;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] din_vals[MAX_K];
  logic [7:0] out_vals[MAX_K];

  always #5 clk = ~clk;

  qpp_deinterleaver #(.DW(DW), .KW(KW), .MAX_K(MAX_K)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len), .f1(f1), .f2(f2),
`ifdef QPP_INTERLEAVE_MODE_EN
    .mode(mode),
`endif
    .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .dout_last(dout_last), .busy(busy), .err(err)
  );

  task automatic check_idle_outputs(input string tag);
    checks++;
    if ({din_ready, dout_valid, dout_last, busy, err} !== 5'b0 || dout !== 8'h00) begin
      errors++;
      $display("FAIL %s: din_ready=%b dout_valid=%b dout_last=%b busy=%b err=%b dout=%h, required all 0",
               tag, din_ready, dout_valid, dout_last, busy, err, dout);
    end
  endtask

  // Drives one block and scoreboards its output. Expected order comes from
  // the direct formula pi(i) = (f1*i + f2*i^2) mod K.
  task automatic run_block(input int k, input int f1v, input int f2v,
                           input bit gaps, input bit rnd_rdy, input bit md);
    int wr_idx = 0, beats = 0, cyc = 0;
    int last_wr_cyc = -1, first_vld_cyc = -1;
    bit pend_wr = 0, hold_chk = 0;
    logic [7:0] held = '0;
    logic [7:0] expv[];
    logic [7:0] e;
    expv = new[k];
    for (int i = 0; i < k; i++) begin
      longint ii = i;
      int p = int'((longint'(f1v) * ii + longint'(f2v) * ii * ii) % longint'(k));
      if (md) expv[i] = din_vals[p];
      else    expv[p] = din_vals[i];
    end
    exp_q.delete();
    for (int i = 0; i < k; i++) exp_q.push_back(expv[i]);

    @(negedge clk);
    start = 1'b1; k_len = KW'(k); f1 = 9'(f1v); f2 = 10'(f2v);
`ifdef QPP_INTERLEAVE_MODE_EN
    mode = md;
`endif
    @(negedge clk);
    start = 1'b0;

    while ((beats < k || busy) && cyc < 4 * k + 100) begin
      if (pend_wr) wr_idx++;
      if (hold_chk) begin
        checks++;
        if (dout_valid !== 1'b1 || dout !== held) begin
          errors++;
          $display("FAIL hold_stable: dout_valid=%b dout=%h, required 1 %h", dout_valid, dout, held);
        end
      end
      if (dout_valid && first_vld_cyc < 0) first_vld_cyc = cyc;

      din_valid  = (wr_idx < k) && (!gaps || (cyc % 2 == 0));
      din        = (wr_idx < k) ? din_vals[wr_idx] : 8'h00;
      dout_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      pend_wr    = din_valid && din_ready;
      if (pend_wr && wr_idx == k - 1) last_wr_cyc = cyc;

      if (dout_valid && dout_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra_beat: got dout=%h, required no beat", dout);
        end else begin
          e = exp_q.pop_front();
          if (dout !== e || dout_last !== (beats == k - 1)) begin
            errors++;
            $display("FAIL beat_%0d: dout=%h last=%b, required %h last=%b",
                     beats, dout, dout_last, e, (beats == k - 1));
          end
          if (beats < MAX_K) out_vals[beats] = dout;
        end
        beats++;
      end
      hold_chk = dout_valid && !dout_ready;
      held     = dout;
      @(negedge clk);
      cyc++;
    end
    din_valid  = 1'b0;
    dout_ready = 1'b0;

    checks++;
    if (beats != k || exp_q.size() != 0) begin
      errors++;
      $display("FAIL beat_count: got %0d beats (%0d unmatched), required %0d", beats, exp_q.size(), k);
    end
    checks++;
    if (busy !== 1'b0 || dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL block_end: busy=%b dout_valid=%b, required 0 0", busy, dout_valid);
    end
    // Last write lands at the edge after last_wr_cyc; first valid is two
    // edges later, seen at the third negedge.
    checks++;
    if (last_wr_cyc < 0 || first_vld_cyc - last_wr_cyc != 3) begin
      errors++;
      $display("FAIL latency: first valid %0d cycles after last write decision, required 3",
               first_vld_cyc - last_wr_cyc);
    end
  endtask

  task automatic fill_ramp(input int k);
    for (int i = 0; i < k; i++) din_vals[i] = 8'(i);
  endtask

  task automatic test_reset;
    @(negedge clk);
    check_idle_outputs("reset_state");
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("after_reset_release");
  endtask

  task automatic test_bad_start;
    int bad[2] = '{0, 6145};
    for (int t = 0; t < 2; t++) begin
      start = 1'b1; k_len = KW'(bad[t]); f1 = 9'd3; f2 = 10'd10;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (err !== 1'b1 || busy !== 1'b0 || din_ready !== 1'b0) begin
        errors++;
        $display("FAIL bad_start_k%0d: err=%b busy=%b din_ready=%b, required 1 0 0", bad[t], err, busy, din_ready);
      end
      @(negedge clk);
      checks++;
      if (err !== 1'b0 || busy !== 1'b0 || din_ready !== 1'b0) begin
        errors++;
        $display("FAIL bad_start_pulse_k%0d: err=%b busy=%b din_ready=%b, required 0 0 0", bad[t], err, busy, din_ready);
      end
    end
  endtask

  task automatic test_basic;
    int cnt[40];
    bit perm_ok = 1;
    fill_ramp(40);
    run_block(40, 3, 10, 0, 0, 0);
    checks++;
    if (out_vals[0] !== 8'd0 || out_vals[13] !== 8'd1 || out_vals[6] !== 8'd2 || out_vals[19] !== 8'd3) begin
      errors++;
      $display("FAIL basic_positions: pos0=%0d pos13=%0d pos6=%0d pos19=%0d, required 0 1 2 3",
               out_vals[0], out_vals[13], out_vals[6], out_vals[19]);
    end
    for (int i = 0; i < 40; i++) cnt[i] = 0;
    for (int i = 0; i < 40; i++) if (out_vals[i] < 40) cnt[out_vals[i]]++;
    for (int i = 0; i < 40; i++) if (cnt[i] != 1) perm_ok = 0;
    checks++;
    if (!perm_ok) begin
      errors++;
      $display("FAIL basic_permutation: output is not a permutation of 0..39, required each once");
    end
  endtask

  task automatic test_gaps_backpressure;
    fill_ramp(40);
    run_block(40, 3, 10, 1, 1, 0);
  endtask

  task automatic test_max_k;
    fill_ramp(MAX_K);
    run_block(MAX_K, 263, 480, 0, 0, 0);
  endtask

  task automatic test_reset_mid_block;
    int n = 0;
    fill_ramp(40);
    @(negedge clk);
    start = 1'b1; k_len = KW'(40); f1 = 9'd3; f2 = 10'd10;
`ifdef QPP_INTERLEAVE_MODE_EN
    mode = 1'b0;
`endif
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 200 && n < 20; c++) begin
      din_valid = 1'b1; din = 8'(n);
      if (din_ready) n++;
      @(negedge clk);
    end
    din_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("mid_block_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("after_mid_reset");
    run_block(40, 3, 10, 0, 0, 0);
  endtask

`ifdef QPP_INTERLEAVE_MODE_EN
  task automatic test_interleave_mode;
    bit ok = 1;
    fill_ramp(40);
    run_block(40, 3, 10, 0, 0, 1);
    for (int i = 0; i < 40; i++) din_vals[i] = out_vals[i];
    run_block(40, 3, 10, 0, 0, 0);
    for (int i = 0; i < 40; i++) if (out_vals[i] !== 8'(i)) ok = 0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL round_trip: deinterleaved output does not restore 0..39");
    end
  endtask
`endif

  initial begin
    rst_n = 1'b0; start = 1'b0; k_len = '0; f1 = '0; f2 = '0;
    din = '0; din_valid = 1'b0; dout_ready = 1'b0;
`ifdef QPP_INTERLEAVE_MODE_EN
    mode = 1'b0;
`endif
    @(negedge clk);
    test_reset();
    test_bad_start();
    test_basic();
    test_gaps_backpressure();
    test_max_k();
    test_reset_mid_block();
`ifdef QPP_INTERLEAVE_MODE_EN
    test_interleave_mode();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
